// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch/CP0 header: default vectors, instruction-memory window and
// the redirect-buffer FSM encoding.
package pc_fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE    = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_SIZE    = 32'h0000_4000;

  // IDLE: no buffered redirect; PENDING: a redirect waits for stall release.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_addr_check.sv
// Combinational address checker: flags word-misaligned addresses and
// addresses outside [IMEM_BASE, IMEM_BASE+IMEM_SIZE). Also used by CP0
// for data-side address errors.
module pc_addr_check
  import pc_fetch_unit_pkg::*;
#(
  parameter int              W         = 32,
  parameter logic [W-1:0]    IMEM_BASE = DEF_IMEM_BASE,
  parameter logic [W-1:0]    IMEM_SIZE = DEF_IMEM_SIZE
) (
  input  logic [W-1:0] addr,
  output logic         bad
);

  // Upper bound is one bit wider so base+size == 2^W stays representable.
  localparam logic [W:0] LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  logic misaligned;
  logic below_base;
  logic above_top;

  // Unsigned alignment and range tests on the fetch address.
  always_comb begin
    misaligned = (addr[1:0] != 2'b00);
    below_base = (addr < IMEM_BASE);
    above_top  = ({1'b0, addr} >= LIMIT);
    bad        = misaligned | below_base | above_top;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: sequential advance, branch/jump redirects,
// exception entry and ERET return, with a one-entry buffer that holds a
// redirect arriving during a stall until the stall releases.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int           W            = 32,
  parameter logic [W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter logic [W-1:0] IMEM_BASE    = DEF_IMEM_BASE,
  parameter logic [W-1:0] IMEM_SIZE    = DEF_IMEM_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         npc_valid,
  input  logic [W-1:0] npc,
  input  logic         exc_req,
  input  logic         eret,
  input  logic [W-1:0] epc,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4,
  output logic         fetch_exc,
  output logic         redirect_pending
);

  localparam logic [W-1:0] FOUR = {{(W-3){1'b0}}, 3'd4};

  fetch_state_t state_reg, state_next;
  logic [W-1:0] pc_reg, pc_next;
  logic [W-1:0] pend_addr_reg, pend_addr_next;

  // Sequential increment wraps modulo 2^W; the wrap shows up via fetch_exc.
  assign pc_plus4         = pc_reg + FOUR;
  assign pc               = pc_reg;
  assign redirect_pending = (state_reg == PENDING);

  // Next-PC priority mux and redirect-buffer FSM.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_plus4;
    pend_addr_next = pend_addr_reg;
    if (exc_req) begin
      // Exception entry ignores stall and discards any buffered redirect.
      pc_next    = EXC_VECTOR;
      state_next = IDLE;
    end else if (eret) begin
      pc_next    = epc;
      state_next = IDLE;
    end else if (stall) begin
      pc_next = pc_reg;
      if (npc_valid) begin
        // Newest redirect wins over an older buffered one.
        pend_addr_next = npc;
        state_next     = PENDING;
      end
    end else if (npc_valid) begin
      // A live redirect supersedes the buffered target.
      pc_next    = npc;
      state_next = IDLE;
    end else if (state_reg == PENDING) begin
      pc_next    = pend_addr_reg;
      state_next = IDLE;
    end
  end

  // State registers with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_VECTOR;
      pend_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pend_addr_reg <= pend_addr_next;
    end
  end

  pc_addr_check #(
    .W         (W),
    .IMEM_BASE (IMEM_BASE),
    .IMEM_SIZE (IMEM_SIZE)
  ) u_addr_check (
    .addr (pc_reg),
    .bad  (fetch_exc)
  );

endmodule
